spi_secondary_rxq: RTL and testbench

Parametrised SPI secondary (slave) receiver, successor to the fixed 8-bit receiver. It adds configurable word width, all four SPI modes, input synchronisation, a first-word-fall-through receive FIFO with valid/ready handshake and overrun flag, and an optional full-duplex MISO transmit path. It sits between the external SPI pins and the command decoder that drives the step/direction outputs.

---
 rtl/spi_secondary_rxq_if.sv | 31 +++
 rtl/spi_secondary_rxq.sv | 178 +++++++++++++++++
 tb/tb_spi_secondary_rxq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_secondary_rxq_if.sv
// Bus bundle for spi_secondary_rxq: SPI pins, receive-queue handshake and transmit word.
// rx handshake: a word transfers on a clk edge where rx_valid && rx_ready; rx_data holds
// steady while rx_valid is high and rx_ready is low, and rx_valid never depends on rx_ready.
interface spi_secondary_rxq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                   sck;
  logic                   cs;
  logic                   mosi;
  logic                   miso;
  logic [WIDTH-1:0]       rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [$clog2(DEPTH):0] rx_level;
  logic                   overrun;
  logic                   overrun_clr;
  logic [WIDTH-1:0]       tx_data;
  logic                   tx_taken;
  logic                   busy;

  modport slave (
    input  sck, cs, mosi, rx_ready, overrun_clr, tx_data,
    output miso, rx_data, rx_valid, rx_level, overrun, tx_taken, busy
  );

  modport master (
    output sck, cs, mosi, rx_ready, overrun_clr, tx_data,
    input  miso, rx_data, rx_valid, rx_level, overrun, tx_taken, busy
  );
endinterface

// File: rtl/spi_secondary_rxq.sv
// SPI secondary receiver: synchronised pins, WIDTH-bit words in any CPOL/CPHA mode, FWFT queue.
// Optional MISO transmit path is built only when SPI_SECONDARY_TX_EN is defined.
module spi_secondary_rxq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input  logic               clk,
  input  logic               rst,
  spi_secondary_rxq_if.slave bus,
  output logic [1:0]         o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic          IDLE_SCK    = (CPOL != 0);
  localparam logic          SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam logic [CW-1:0] CNT_WORD    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [AW:0]   LVL_FULL    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  typedef enum logic [1:0] {ST_LOCKOUT = 2'd0, ST_IDLE = 2'd1, ST_FRAME = 2'd2} state_t;

  logic [1:0]       r_sck_sync, r_cs_sync, r_mosi_sync;
  logic             r_sck_d;
  logic             w_sck_s, w_cs_s, w_mosi_s;
  logic             w_sample_edge, w_shift_edge;
  state_t           r_state, w_next;
  logic             w_frame_start, w_in_frame, w_busy;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_sh;
  logic             w_word_done;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_overrun;
  logic             w_full, w_pop, w_wr, w_ovf;

  // cs sync resets to "asserted" so a frame already running across reset is locked out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= {2{IDLE_SCK}};
      r_sck_d     <= IDLE_SCK;
      r_cs_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], bus.sck};
      r_sck_d     <= r_sck_sync[1];
      r_cs_sync   <= {r_cs_sync[0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
    end
  end

  assign w_sck_s       = r_sck_sync[1];
  assign w_cs_s        = r_cs_sync[1];
  assign w_mosi_s      = r_mosi_sync[1];
  assign w_sample_edge = SAMPLE_RISE ? (w_sck_s & ~r_sck_d) : (~w_sck_s & r_sck_d);
  assign w_shift_edge  = SAMPLE_RISE ? (~w_sck_s & r_sck_d) : (w_sck_s & ~r_sck_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOCKOUT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOCKOUT: if (w_cs_s)  w_next = ST_IDLE;
      ST_IDLE:    if (!w_cs_s) w_next = ST_FRAME;
      ST_FRAME:   if (w_cs_s)  w_next = ST_IDLE;
      default:                 w_next = ST_LOCKOUT;
    endcase
  end

  always_comb begin
    w_frame_start = 1'b0;
    w_in_frame    = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      ST_IDLE:  w_frame_start = !w_cs_s;
      ST_FRAME: begin
        w_in_frame = !w_cs_s;
        w_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_word_done = (r_bit_cnt == CNT_WORD);

  // A completed word is pushed even if cs rises in the same cycle; partial words never are
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
    end else if (!w_in_frame || w_word_done) begin
      r_bit_cnt <= '0;
    end else if (w_sample_edge) begin
      r_bit_cnt <= r_bit_cnt + CNT_ONE;
      r_rx_sh   <= {r_rx_sh[WIDTH-2:0], w_mosi_s};
    end
  end

  assign w_full = (r_level == LVL_FULL);
  assign w_pop  = bus.rx_valid && bus.rx_ready;
  assign w_wr   = w_word_done && (!w_full || w_pop);
  assign w_ovf  = w_word_done && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_rx_sh;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_ovf)                r_overrun <= 1'b1;
      else if (bus.overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign bus.rx_data   = r_mem[r_rd_ptr];
  assign bus.rx_valid  = (r_level != '0);
  assign bus.rx_level  = r_level;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = w_busy;
  assign o_dbg_state   = r_state;

`ifdef SPI_SECONDARY_TX_EN
  logic [WIDTH-1:0] r_tx_sh;
  logic             r_miso, r_tx_taken;
  logic             w_load;

  assign w_load = w_frame_start || (w_in_frame && w_word_done);

  // CPHA=0 preloads the MSB, so the trailing edge that ends each word must not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_sh    <= '0;
      r_miso     <= 1'b0;
      r_tx_taken <= 1'b0;
    end else begin
      r_tx_taken <= w_load;
      if (!w_in_frame && !w_frame_start) begin
        r_miso <= 1'b0;
      end else if (w_load) begin
        if (CPHA == 0) begin
          r_miso  <= bus.tx_data[WIDTH-1];
          r_tx_sh <= {bus.tx_data[WIDTH-2:0], 1'b0};
        end else begin
          r_tx_sh <= bus.tx_data;
        end
      end else if (w_shift_edge && (CPHA != 0 || r_bit_cnt != '0)) begin
        r_miso  <= r_tx_sh[WIDTH-1];
        r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.tx_taken = r_tx_taken;
`else
  assign bus.miso     = 1'b0;
  assign bus.tx_taken = 1'b0;
`endif
endmodule

// File: tb/tb_spi_secondary_rxq.sv
// Directed bench for spi_secondary_rxq: one DUT per SPI mode sharing cs/mosi, mode 0 checked in depth.
module tb_spi_secondary_rxq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck_base = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] tx_data = 8'h5A;
  logic [1:0] dbg0, dbg1, dbg2, dbg3;
  int         n_asserts = 0;
  int         n_fail = 0;
  int         taken_cnt = 0;

  always #5 clk = ~clk;

  spi_secondary_rxq_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  spi_secondary_rxq_if #(.WIDTH(8), .DEPTH(4)) if1 ();
  spi_secondary_rxq_if #(.WIDTH(8), .DEPTH(4)) if2 ();
  spi_secondary_rxq_if #(.WIDTH(8), .DEPTH(4)) if3 ();

  assign if0.sck = sck_base;
  assign if1.sck = sck_base;
  assign if2.sck = ~sck_base;
  assign if3.sck = ~sck_base;
  assign {if0.cs, if1.cs, if2.cs, if3.cs}                 = {4{cs}};
  assign {if0.mosi, if1.mosi, if2.mosi, if3.mosi}         = {4{mosi}};
  assign {if0.rx_ready, if1.rx_ready, if2.rx_ready, if3.rx_ready} = {4{rx_ready}};
  assign {if0.overrun_clr, if1.overrun_clr, if2.overrun_clr, if3.overrun_clr} = {4{overrun_clr}};
  assign if0.tx_data = tx_data;
  assign if1.tx_data = tx_data;
  assign if2.tx_data = tx_data;
  assign if3.tx_data = tx_data;

  spi_secondary_rxq #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0), .o_dbg_state(dbg0));
  spi_secondary_rxq #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1), .o_dbg_state(dbg1));
  spi_secondary_rxq #(.WIDTH(8), .DEPTH(4), .CPOL(1), .CPHA(0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2), .o_dbg_state(dbg2));
  spi_secondary_rxq #(.WIDTH(8), .DEPTH(4), .CPOL(1), .CPHA(1)) u_dut3 (.clk(clk), .rst(rst), .bus(if3), .o_dbg_state(dbg3));

  logic [7:0] m_data [4];
  logic       m_valid [4];
  logic [2:0] m_level [4];
  logic       m_ovr [4];
  assign m_data  = '{if0.rx_data, if1.rx_data, if2.rx_data, if3.rx_data};
  assign m_valid = '{if0.rx_valid, if1.rx_valid, if2.rx_valid, if3.rx_valid};
  assign m_level = '{if0.rx_level, if1.rx_level, if2.rx_level, if3.rx_level};
  assign m_ovr   = '{if0.overrun, if1.overrun, if2.overrun, if3.overrun};

  always @(negedge clk) if (if0.tx_taken === 1'b1) taken_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Host: mosi is stable across both edges of each bit, so every CPHA samples it correctly
  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      #20;
      rd = {rd[6:0], if0.miso};
      sck_base = 1'b1;
      #40;
      sck_base = 1'b0;
      #20;
    end
  endtask

  task automatic frame_open();
    cs = 1'b0;
    #80;
  endtask

  task automatic frame_close();
    cs = 1'b1;
    #100;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    #10;
    rx_ready = 1'b0;
    #10;
  endtask

  initial begin
    logic [7:0] rd;
    int         t0;

    // reset values
    #2 rst = 1'b1;
    #28;
    check("rst_miso", if0.miso, 0);
    check("rst_valid", if0.rx_valid, 0);
    check("rst_level", if0.rx_level, 0);
    check("rst_overrun", if0.overrun, 0);
    check("rst_tx_taken", if0.tx_taken, 0);
    check("rst_busy", if0.busy, 0);
    check("rst_data", if0.rx_data, 0);
    #10 rst = 1'b0;
    #50;

    // all four modes: two words in one frame
    frame_open();
    check("busy_in_frame", if0.busy, 1);
    xfer(8'h3C, 8, rd);
    xfer(8'hC3, 8, rd);
    frame_close();
    check("busy_after_frame", if0.busy, 0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("mode%0d_level2", m), m_level[m], 2);
      check($sformatf("mode%0d_head_3c", m), m_data[m], 8'h3C);
    end
    pop_one();
    for (int m = 0; m < 4; m++) begin
      check($sformatf("mode%0d_level1", m), m_level[m], 1);
      check($sformatf("mode%0d_head_c3", m), m_data[m], 8'hC3);
    end
    pop_one();
    for (int m = 0; m < 4; m++) check($sformatf("mode%0d_empty", m), m_valid[m], 0);

    // mode 0 latency: valid within 5 clk of final sample edge, consumed next cycle
    rx_ready = 1'b1;
    frame_open();
    xfer(8'hA5, 7, rd);
    mosi = 1'b1;
    #20;
    check("a5_not_early", if0.rx_valid, 0);
    sck_base = 1'b1;
    #40;
    check("a5_valid", if0.rx_valid, 1);
    check("a5_data", if0.rx_data, 8'hA5);
    #10;
    check("a5_popped_valid", if0.rx_valid, 0);
    check("a5_popped_level", if0.rx_level, 0);
    #30 sck_base = 1'b0;
    #20;
    frame_close();
    rx_ready = 1'b0;
    check("a5_single_word", if0.rx_level, 0);

    // overrun: five words into a four-deep queue
    frame_open();
    for (int k = 1; k <= 5; k++) xfer(8'(k), 8, rd);
    frame_close();
    check("ovr_level", if0.rx_level, 4);
    check("ovr_flag", if0.overrun, 1);
    check("ovr_flag_mode3", m_ovr[3], 1);
    overrun_clr = 1'b1;
    #10 overrun_clr = 1'b0;
    #10;
    check("ovr_cleared", if0.overrun, 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr_word%0d", k), if0.rx_data, k);
      pop_one();
    end
    check("ovr_drained", if0.rx_valid, 0);

    // abort mid-word, then a clean word
    frame_open();
    xfer(8'hB0, 5, rd);
    frame_close();
    check("abort_no_push", if0.rx_level, 0);
    frame_open();
    xfer(8'h81, 8, rd);
    frame_close();
    check("abort_level", if0.rx_level, 1);
    check("abort_data", if0.rx_data, 8'h81);
    pop_one();

    // transmit path, mode 0
    t0 = taken_cnt;
    frame_open();
    xfer(8'hFF, 8, rd);
    frame_close();
`ifdef SPI_SECONDARY_TX_EN
    check("tx_miso_word", rd, 8'h5A);
    check("tx_taken_pulses", taken_cnt - t0, 2);
`else
    check("tx_miso_tied", rd, 8'h00);
    check("tx_taken_tied", taken_cnt - t0, 0);
`endif
    check("tx_miso_idle", if0.miso, 0);
    check("tx_rx_data", if0.rx_data, 8'hFF);
    pop_one();

    // async reset mid-word with three queued
    frame_open();
    xfer(8'h11, 8, rd);
    xfer(8'h22, 8, rd);
    xfer(8'h33, 8, rd);
    xfer(8'h40, 4, rd);
    check("prerst_level", if0.rx_level, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_level", if0.rx_level, 0);
    check("mid_rst_valid", if0.rx_valid, 0);
    check("mid_rst_data", if0.rx_data, 0);
    check("mid_rst_busy", if0.busy, 0);
    check("mid_rst_miso", if0.miso, 0);
    check("mid_rst_taken", if0.tx_taken, 0);
    check("mid_rst_level_mode3", m_level[3], 0);
    #19 rst = 1'b0;
    #40;
    xfer(8'h99, 8, rd);
    check("lockout_level", if0.rx_level, 0);
    check("lockout_busy", if0.busy, 0);
    frame_close();
    frame_open();
    xfer(8'h77, 8, rd);
    frame_close();
    check("post_rst_level", if0.rx_level, 1);
    check("post_rst_data", if0.rx_data, 8'h77);
    pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
